pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Parametrised fetch-PC generator for the pipelined core, replacing the fixed 32-bit branch/jump PC register.
//  Selects next PC by fixed priority: reset, trap, branch, return, jump, stall, sequential.
//  Adds a return-address stack (RAS) so jr-style returns redirect without waiting on the register file.
//  Flags conflicting redirects, RAS underflow and misaligned targets.
//  Sits in IF; redirect requests come from EX/ID, stall from the hazard unit.
// PARAMETERS
//  PC_W       32            PC / address width
//  RESET_VEC  32'h0000_3000 PC loaded on reset
//  TRAP_VEC   32'h0000_4180 PC loaded on trap
//  INC        4             sequential increment
//  RAS_DEPTH  4             RAS entries, power of two, >=2
//  ALIGN_B    2             low target bits forced to 0
// PORTS
//  Clk             in   1         clock, all state on rising edge
//  PcReSet         in   1         synchronous active-high reset
//  do_stall        in   1         hold PC (sequential path only)
//  trap            in   1         exception redirect to TRAP_VEC
//  branch_taken    in   1         branch redirect request
//  branch_addr     in   PC_W      branch target
//  jump_taken      in   1         jump redirect request
//  jump_addr       in   PC_W      jump target; also fallback target for ret on empty RAS
//  call_push       in   1         jump is a call: push call_ret_addr
//  call_ret_addr   in   PC_W      return address to push
//  ret_taken       in   1         return: pop RAS and redirect to popped entry
//  PC              out  PC_W      current fetch PC
//  ras_count       out  $clog2(RAS_DEPTH)+1  valid RAS entries
//  redirect_conflict out 1        registered pulse: >1 of branch/jump/ret asserted
//  ras_underflow   out  1         registered pulse: ret_taken with empty RAS
//  misaligned      out  1         registered pulse: selected target had nonzero low ALIGN_B bits
// BEHAVIOUR
//  - Reset (PcReSet=1 at edge): PC=RESET_VEC, ras_count=0, RAS ptr=0, all pulses 0. Overrides every other input.
//    Mid-operation reset discards pending push/pop.
//  - Priority per edge: trap > branch > ret > jump > do_stall hold > PC+INC.
//    Redirects win over do_stall: a redirect updates PC even when stalled.
//  - Targets: next PC = target with low ALIGN_B bits cleared; misaligned=1 next cycle if they were nonzero.
//  - Sequential: PC+INC modulo 2^PC_W; wrap from all-ones is legal and silent.
//  - ret: RAS non-empty -> PC=top, pop. RAS empty -> PC=jump_addr, count stays 0, ras_underflow=1.
//  - push (call_push & jump_taken & jump selected): write call_ret_addr at ptr, ptr++, count=min(count+1,RAS_DEPTH).
//    Full push overwrites the oldest entry (circular).
//  - call_push without jump_taken: ignored.
//  - Push and pop are suppressed when a higher-priority redirect (trap/branch) wins the cycle; RAS is unchanged.
//  - Same cycle ret_taken & call_push & jump_taken: ret wins, pop only, redirect_conflict=1.
//  - redirect_conflict: set one cycle after any edge where >=2 of {branch_taken, ret_taken, jump_taken}
//    are high. Trap does not count toward the conflict.
//  - Latency: every request sampled at edge N is visible on PC after edge N; no combinational path input->PC.
//  - RAS state is unaffected by do_stall alone.
// STRUCTURE
//  - Package pc_unit_pkg:
//    - SEL_* next-PC select encoding (SEL_SEQ, SEL_HOLD, SEL_JUMP, SEL_RET, SEL_BRANCH, SEL_TRAP).
//    - Default RESET_VEC/TRAP_VEC constants.
//  - Sub-module pc_ras (circular stack).
//    - Ports: Clk, PcReSet, push, pop, push_data, top, count.
//    - Owns ptr/count and the full-overwrite/empty rules.
//  - Top: priority encoder -> SEL_*, next-PC mux, alignment mask, flag registers.
// TESTING
//  1. Reset with defaults: PcReSet=1 one edge -> PC=0x3000, ras_count=0. Then 3 free edges -> 0x3004, 0x3008, 0x300C.
//  2. Stall vs redirect: do_stall=1 for 2 edges -> PC held. With do_stall=1 + branch_taken, branch_addr=0x3100
//     -> PC=0x3100 next edge.
//  3. Call/return: jump_taken+call_push, jump_addr=0x3200, call_ret_addr=0x3010 -> PC=0x3200, count=1.
//     Then ret_taken -> PC=0x3010, count=0.
//  4. RAS overflow/underflow (DEPTH=4): 5 pushes of 0xA0..0xB0 -> count=4; 4 pops return 0xB0, 0xAC, 0xA8, 0xA4.
//     5th ret with jump_addr=0x3300 -> PC=0x3300, ras_underflow=1.
//  5. Priority/conflict: trap+branch+jump same edge -> PC=0x4180, RAS unchanged, redirect_conflict=1.
//     branch+ret -> PC=branch_addr, no pop, redirect_conflict=1.
//  6. Alignment/wrap: branch_addr=0x3103 -> PC=0x3100, misaligned=1. PC=0xFFFF_FFFC sequential -> 0x0000_0000.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-PC redirect unit: next-PC select codes and default vectors.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_JUMP,
    SEL_RET,
    SEL_BRANCH,
    SEL_TRAP
  } pcSelT;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_4180;

  // Number of simultaneous branch/ret/jump requests; trap is deliberately excluded.
  function automatic logic [1:0] countRedirects(input logic branchReq,
                                                input logic retReq,
                                                input logic jumpReq);
    return 2'(branchReq) + 2'(retReq) + 2'(jumpReq);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_ras.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     PcReSet,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign top = mem[ptr - PTR_W'(1)];

  // Pop takes precedence if both arrive; an empty pop leaves the stack untouched.
  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      ptr   <= '0;
      count <= '0;
    end else if (pop) begin
      if (count != '0) begin
        ptr   <= ptr - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!PcReSet && !pop && push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-PC generator: prioritised redirects, return-address stack, and registered error pulses.
module pc_redirect_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEFAULT_RESET_VEC),
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(DEFAULT_TRAP_VEC),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4,
  parameter int              ALIGN_B   = 2
) (
  input  logic                         Clk,
  input  logic                         PcReSet,
  input  logic                         do_stall,
  input  logic                         trap,
  input  logic                         branch_taken,
  input  logic [PC_W-1:0]              branch_addr,
  input  logic                         jump_taken,
  input  logic [PC_W-1:0]              jump_addr,
  input  logic                         call_push,
  input  logic [PC_W-1:0]              call_ret_addr,
  input  logic                         ret_taken,
  output logic [PC_W-1:0]              PC,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         redirect_conflict,
  output logic                         ras_underflow,
  output logic                         misaligned
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~((PC_W'(1) << ALIGN_B) - PC_W'(1));

  pcSelT           sel;
  logic [PC_W-1:0] rawTarget;
  logic [PC_W-1:0] nextPc;
  logic [PC_W-1:0] rasTop;
  logic            rasEmpty;
  logic            isRedirect;
  logic            rasPush;
  logic            rasPop;

  assign rasEmpty = (ras_count == '0);

  always_comb begin
    sel = SEL_SEQ;
    if (trap)              sel = SEL_TRAP;
    else if (branch_taken) sel = SEL_BRANCH;
    else if (ret_taken)    sel = SEL_RET;
    else if (jump_taken)   sel = SEL_JUMP;
    else if (do_stall)     sel = SEL_HOLD;
  end

  // An empty-stack return falls back to the jump target supplied alongside it.
  always_comb begin
    rawTarget  = '0;
    isRedirect = 1'b1;
    unique case (sel)
      SEL_TRAP:   rawTarget = TRAP_VEC;
      SEL_BRANCH: rawTarget = branch_addr;
      SEL_RET:    rawTarget = rasEmpty ? jump_addr : rasTop;
      SEL_JUMP:   rawTarget = jump_addr;
      default:    isRedirect = 1'b0;
    endcase
  end

  always_comb begin
    nextPc = PC + PC_W'(INC);
    if (isRedirect)            nextPc = rawTarget & ALIGN_MASK;
    else if (sel == SEL_HOLD)  nextPc = PC;
  end

  assign rasPush = (sel == SEL_JUMP) && call_push && !PcReSet;
  assign rasPop  = (sel == SEL_RET) && !rasEmpty && !PcReSet;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) uRas (
    .Clk       (Clk),
    .PcReSet   (PcReSet),
    .push      (rasPush),
    .pop       (rasPop),
    .push_data (call_ret_addr),
    .top       (rasTop),
    .count     (ras_count)
  );

  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      PC                <= RESET_VEC;
      redirect_conflict <= 1'b0;
      ras_underflow     <= 1'b0;
      misaligned        <= 1'b0;
    end else begin
      PC                <= nextPc;
      redirect_conflict <= (countRedirects(branch_taken, ret_taken, jump_taken) >= 2'd2);
      ras_underflow     <= (sel == SEL_RET) && rasEmpty;
      misaligned        <= isRedirect && ((rawTarget & ~ALIGN_MASK) != '0);
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed-vector bench for pc_redirect_unit: table of per-cycle inputs with hand-computed results.
module tb_pc_redirect_unit;

  logic        Clk;
  logic        PcReSet;
  logic        do_stall;
  logic        trap;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic        call_push;
  logic [31:0] call_ret_addr;
  logic        ret_taken;
  logic [31:0] PC;
  logic [2:0]  ras_count;
  logic        redirect_conflict;
  logic        ras_underflow;
  logic        misaligned;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        trp;
    logic        br;
    logic [31:0] bAddr;
    logic        jmp;
    logic [31:0] jAddr;
    logic        push;
    logic [31:0] rAddr;
    logic        ret;
    logic [31:0] ePc;
    logic [2:0]  eCnt;
    logic        eConf;
    logic        eUnd;
    logic        eMis;
  } vecT;

  vecT vecs[$];
  int  vecCount  = 0;
  int  missCount = 0;

  pc_redirect_unit dut (
    .Clk               (Clk),
    .PcReSet           (PcReSet),
    .do_stall          (do_stall),
    .trap              (trap),
    .branch_taken      (branch_taken),
    .branch_addr       (branch_addr),
    .jump_taken        (jump_taken),
    .jump_addr         (jump_addr),
    .call_push         (call_push),
    .call_ret_addr     (call_ret_addr),
    .ret_taken         (ret_taken),
    .PC                (PC),
    .ras_count         (ras_count),
    .redirect_conflict (redirect_conflict),
    .ras_underflow     (ras_underflow),
    .misaligned        (misaligned)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic addVec(input logic rst, input logic stall, input logic trp,
                        input logic br, input logic [31:0] bAddr,
                        input logic jmp, input logic [31:0] jAddr,
                        input logic push, input logic [31:0] rAddr, input logic ret,
                        input logic [31:0] ePc, input logic [2:0] eCnt,
                        input logic eConf, input logic eUnd, input logic eMis);
    vecT v;
    v.rst = rst; v.stall = stall; v.trp = trp; v.br = br; v.bAddr = bAddr;
    v.jmp = jmp; v.jAddr = jAddr; v.push = push; v.rAddr = rAddr; v.ret = ret;
    v.ePc = ePc; v.eCnt = eCnt; v.eConf = eConf; v.eUnd = eUnd; v.eMis = eMis;
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs at the falling edge and lets one rising edge pass.
  task automatic applyStimulus(input vecT v);
    PcReSet = v.rst; do_stall = v.stall; trap = v.trp;
    branch_taken = v.br; branch_addr = v.bAddr;
    jump_taken = v.jmp; jump_addr = v.jAddr;
    call_push = v.push; call_ret_addr = v.rAddr; ret_taken = v.ret;
    @(posedge Clk);
    #1;
    vecCount++;
  endtask

  task automatic checkOutput(input string name, input vecT v);
    if (PC !== v.ePc) begin
      missCount++;
      $display("[TB] FAIL %s pc: got %h expected %h", name, PC, v.ePc);
    end
    if (ras_count !== v.eCnt) begin
      missCount++;
      $display("[TB] FAIL %s ras_count: got %0d expected %0d", name, ras_count, v.eCnt);
    end
    if (redirect_conflict !== v.eConf) begin
      missCount++;
      $display("[TB] FAIL %s conflict: got %b expected %b", name, redirect_conflict, v.eConf);
    end
    if (ras_underflow !== v.eUnd) begin
      missCount++;
      $display("[TB] FAIL %s underflow: got %b expected %b", name, ras_underflow, v.eUnd);
    end
    if (misaligned !== v.eMis) begin
      missCount++;
      $display("[TB] FAIL %s misaligned: got %b expected %b", name, misaligned, v.eMis);
    end
  endtask

  initial begin
    PcReSet = 1'b0; do_stall = 1'b0; trap = 1'b0;
    branch_taken = 1'b0; branch_addr = '0; jump_taken = 1'b0; jump_addr = '0;
    call_push = 1'b0; call_ret_addr = '0; ret_taken = 1'b0;

    //     rst st tr br bAddr         jmp jAddr         push rAddr       ret  ePc           cnt cf un mi
    addVec(1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_3000, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_3004, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_3008, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_300C, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_300C, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_300C, 0, 0, 0, 0);
    addVec(0, 1, 0, 1, 32'h0000_3100, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3100, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3200, 1, 32'h0000_3010, 0, 32'h0000_3200, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0000_3010, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3400, 1, 32'h0000_00A0, 0, 32'h0000_3400, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3400, 1, 32'h0000_00A4, 0, 32'h0000_3400, 2, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3400, 1, 32'h0000_00A8, 0, 32'h0000_3400, 3, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3400, 1, 32'h0000_00AC, 0, 32'h0000_3400, 4, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3400, 1, 32'h0000_00B0, 0, 32'h0000_3400, 4, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0000_00B0, 3, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0000_00AC, 2, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0000_00A8, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0000_00A4, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0000_3300, 0, 32'h0,         1, 32'h0000_3300, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_3304, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3500, 1, 32'h0000_1000, 0, 32'h0000_3500, 1, 0, 0, 0);
    addVec(0, 0, 1, 1, 32'h0000_3100, 1, 32'h0000_3600, 1, 32'h0000_2000, 0, 32'h0000_4180, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 32'h0000_3700, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3700, 1, 1, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3800, 1, 32'h0000_2000, 1, 32'h0000_1000, 0, 1, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_1004, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 32'h0000_3103, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3100, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_3104, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_5000, 0, 32'h0000_0004, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_4180, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h0000_3602, 1, 32'h0000_0111, 0, 32'h0000_3600, 1, 0, 0, 1);
    // Multi-cycle corner: reset in the same cycle as a call discards the push.
    addVec(1, 0, 0, 0, 32'h0,         1, 32'h0000_3900, 1, 32'h0000_7000, 0, 32'h0000_3000, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0000_3A00, 0, 32'h0,         1, 32'h0000_3A00, 0, 0, 1, 0);
    addVec(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0000_3A00, 0, 0, 0, 0);

    @(negedge Clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
